// File: rtl/uart_rx_ctrl.sv
// UART receive buffer: captures bytes with a framing flag into a FIFO, keeps sticky error status, and raises level and character-timeout interrupts.
// Status updates one cycle after a push or pop and irq one cycle after that; a push into a full FIFO without a pop is dropped and sets ovr.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 4,
  parameter int TIMEOUT_BCLK = 640
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  bclk_i,
  input  logic                  rx_done_i,
  input  logic [DATA_WIDTH-1:0] rx_dout_i,
  input  logic                  rx_line_i,
  input  logic                  en_i,
  input  logic                  flush_i,
  input  logic                  clr_err_i,
  input  logic [ADDR_WIDTH:0]   thresh_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH:0]   rd_data_o,
  output logic                  rd_valid_o,
  output logic [ADDR_WIDTH:0]   level_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  ovr_o,
  output logic                  ferr_o,
  output logic                  timeout_o,
  output logic                  irq_o
);

  localparam int                  DEPTH   = 2 ** ADDR_WIDTH;
  localparam int                  CW      = (TIMEOUT_BCLK > 1) ? $clog2(TIMEOUT_BCLK) : 1;
  localparam logic [ADDR_WIDTH:0] LVL_MAX = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LVL_ONE = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
  localparam logic [CW-1:0]       CNT_MAX = CW'(TIMEOUT_BCLK - 1);
  localparam logic [CW-1:0]       CNT_ONE = CW'(1);

  typedef enum logic [1:0] {T_IDLE, T_COUNT, T_EXPIRED} tstate_e;

  logic [DATA_WIDTH:0]   mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   level_q, level_d;
  logic [DATA_WIDTH:0]   rd_data_q;
  logic                  rd_valid_q, ovr_q, ovr_d, ferr_q, ferr_d, irq_q, irq_d;
  tstate_e               state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic empty, full, push_req, pop_ok, push_ok, activity;

  assign empty    = (level_q == '0);
  assign full     = (level_q == LVL_MAX);
  assign push_req = rx_done_i & en_i;
  assign pop_ok   = rd_en_i & ~empty & ~flush_i;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok  = push_req & (~full | pop_ok) & ~flush_i;
  assign activity = push_ok | pop_ok;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
    end
  end

  // Set events beat a simultaneous clear.
  assign ovr_d  = (push_req & full & ~pop_ok & ~flush_i) | (ovr_q & ~clr_err_i);
  assign ferr_d = (push_ok & ~rx_line_i) | (ferr_q & ~clr_err_i);
  assign irq_d  = ((thresh_i != '0) && (level_q >= thresh_i)) |
                  (state_q == T_EXPIRED) | ovr_q | ferr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush_i || level_d == '0) begin
      state_d = T_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        T_IDLE: begin
          state_d = T_COUNT;
          cnt_d   = '0;
        end
        T_COUNT: begin
          if (activity) begin
            cnt_d = '0;
          end else if (bclk_i) begin
            if (cnt_q == CNT_MAX) begin
              state_d = T_EXPIRED;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end
        T_EXPIRED: begin
          if (activity) begin
            state_d = T_COUNT;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = T_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr_q] <= {~rx_line_i, rx_dout_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
      irq_q      <= 1'b0;
      state_q    <= T_IDLE;
      cnt_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      rd_valid_q <= pop_ok;
      if (pop_ok) rd_data_q <= mem[rd_ptr_q];
      ovr_q      <= ovr_d;
      ferr_q     <= ferr_d;
      irq_q      <= irq_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign level_o    = level_q;
  assign empty_o    = empty;
  assign full_o     = full;
  assign ovr_o      = ovr_q;
  assign ferr_o     = ferr_q;
  assign timeout_o  = (state_q == T_EXPIRED);
  assign irq_o      = irq_q;

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller between `uart_rx` and the host/bus side of the UART. Captures each byte when `uart_rx` pulses `rx_done` and checks the stop bit. Buffers each byte with its framing-error flag in an internal FIFO. Raises sticky overrun and framing status, a FIFO-level interrupt and a character-timeout interrupt, with the timeout counted in oversampling `bclk` ticks.

## Interface
- `DATA_WIDTH`, 8: received byte width; must match `uart_rx`.
- `ADDR_WIDTH`, 4: FIFO address width; depth = 2**ADDR_WIDTH (16).
- `TIMEOUT_BCLK`, 640: `bclk` ticks of inactivity before the timeout flag sets (4 char times at 16x oversampling).
- `clk` input 1: system clock; all logic on its rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `bclk` input 1: 1-cycle baud-tick strobe, 16x baud, from the baud generator.
- `rx_done` input 1: 1-cycle byte-complete pulse from `uart_rx`.
- `rx_dout` input DATA_WIDTH: received byte; valid in the `rx_done` cycle.
- `rx_line` input 1: serial line; sampled in the `rx_done` cycle as the stop bit.
- `en` input 1: when 0, `rx_done` is ignored and no byte is stored.
- `flush` input 1: synchronous FIFO clear pulse.
- `clr_err` input 1: clears the sticky `ovr` and `ferr` flags.
- `thresh` input ADDR_WIDTH+1: level-interrupt threshold; 0 disables the level interrupt.
- `rd_en` input 1: host pop request.
- `rd_data` output DATA_WIDTH+1: {ferr bit, byte} of the popped entry.
- `rd_valid` output 1: `rd_data` valid pulse.
- `level` output ADDR_WIDTH+1: current FIFO occupancy, 0..DEPTH.
- `empty`, `full` output 1 each: FIFO status.
- `ovr` output 1: sticky overrun flag.
- `ferr` output 1: sticky framing-error flag.
- `timeout` output 1: character-timeout flag.
- `irq` output 1: interrupt request.

## Operation
- **Push:** in a cycle with `rx_done`=1 and `en`=1, store entry {~rx_line, rx_dout}. The stored bit is 1 when the stop bit sampled low; in that case `ferr` is also set.
- **Overrun:** a push while `full`=1, with no pop in the same cycle, drops the byte and sets `ovr`. FIFO contents are unchanged.
- **Pop:** `rd_en`=1 while `empty`=0 pops the head entry. `rd_en` while empty is ignored, with no underflow and no `rd_valid`.
- **Simultaneous push and pop:**
  - When full: both are accepted, `level` is unchanged and `ovr` does not set.
  - When empty: only the push takes effect.
- **Flush:** `flush`=1 clears the pointers and sets `level` to 0, with priority over a push or pop in the same cycle. `ovr` and `ferr` are not affected.
- **Error clear:** `clr_err` clears `ovr` and `ferr`. If a set event occurs in the same cycle, the set wins.
- **Pointers:** ADDR_WIDTH bits, wrapping modulo DEPTH. `level` = writes − reads and is never greater than DEPTH.
- **Timeout FSM:**
  - T_IDLE: entered when `empty` is 1, or on `flush`; counter held at 0.
  - T_IDLE → T_COUNT: when the FIFO becomes non-empty.
  - T_COUNT: counter increments on each `bclk`. Any accepted push or pop resets it to 0. It goes to T_IDLE if the FIFO becomes empty, and to T_EXPIRED when the counter reaches TIMEOUT_BCLK−1 on a `bclk`.
  - T_EXPIRED: `timeout`=1. Any accepted push or pop returns to T_COUNT with the counter at 0 and drops `timeout`, or goes to T_IDLE if the FIFO becomes empty. `flush` → T_IDLE.
- **Interrupt:** `irq` = ((thresh != 0) && (level >= thresh)) | timeout | ovr | ferr, registered.

## Timing
- **Reset values:** `rd_data`=0, `rd_valid`=0, `level`=0, `empty`=1, `full`=0, `ovr`=0, `ferr`=0, `timeout`=0, `irq`=0; FSM in T_IDLE; pointers at 0. Reset asserted mid-operation discards all FIFO contents immediately.
- **Push latency:** a push in cycle N updates `level`, `empty` and `full` at edge N+1. The byte can be popped from cycle N+1 onward.
- **Pop latency:** `rd_en` in cycle N gives `rd_data` and a 1-cycle `rd_valid` at edge N+1. `rd_data` holds its value until the next pop.
- **Flag timing:** `ovr` and `ferr` set at edge N+1 after the causing event. `irq` follows its inputs one cycle later, at edge N+2.
- **Timeout timing:** `timeout` asserts on the edge after the TIMEOUT_BCLK-th `bclk` with no FIFO activity.
- **Streaming:** one push and one pop per cycle are sustainable indefinitely.

## Test plan
- **Single byte:** 0xA5 with `rx_line`=1, then `rd_en` → `rd_data`=0x0A5 one cycle later, `rd_valid` for 1 cycle, `level` 1→0, `ferr`=0.
- **Framing error:** 0x3C with `rx_line`=0 → `rd_data`=0x13C, `ferr`=1 and `irq`=1. `clr_err` → both clear.
- **Overrun:** 17 pushes of 0x00..0x10 with no reads → `full`=1, `ovr`=1, 0x10 dropped. 16 pops return 0x00..0x0F in order, then `empty`=1.
- **Simultaneous ops:** with the FIFO full, push 0x55 and `rd_en` in the same cycle → `level` stays 16, `ovr`=0, 0x55 is read last. `flush` with `rd_en` → `level`=0, no `rd_valid`.
- **Timeout:** 1 byte stored, `thresh`=4 → `timeout` sets after exactly 640 `bclk`s; 639 `bclk`s followed by a push → no timeout. A pop clears `timeout`.
- **Level irq and reset:** `thresh`=3, 3 pushes → `irq`=1 two cycles after the third push. Asserting `rst`=0 mid-stream → all outputs return to reset values at once.
